// File: rtl/ussub_pkg.sv
// rtl/ussub_pkg.sv - shared width helpers for the scaled unary add/subtract datapath
package ussub_pkg;

    localparam int DEF_NUM_IN = 4;

    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

    function automatic int pc_w(input int num_in);
        return clog2(num_in + 1);
    endfunction

    // Residue register needs at least one bit even when NUM_IN collapses clog2 to zero.
    function automatic int acc_w(input int num_in);
        return (clog2(num_in) < 1) ? 1 : clog2(num_in);
    endfunction

    function automatic int sum_w(input int num_in);
        return clog2(2 * num_in);
    endfunction

    localparam int PC_W  = pc_w(DEF_NUM_IN);
    localparam int ACC_W = acc_w(DEF_NUM_IN);
    localparam int SUM_W = sum_w(DEF_NUM_IN);

endpackage

// File: rtl/u_scaled_addsub_n_popcnt.sv
// rtl/u_scaled_addsub_n_popcnt.sv - registered N-bit popcount of sign-adjusted lanes (stage 1)
module u_popcnt_reg
    import ussub_pkg::*;
#(
    parameter int N = 4,
    parameter int W = pc_w(4)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         valid,
    input  logic [N-1:0] in_bits,
    input  logic [N-1:0] sub_mask,
    output logic [W-1:0] pc,
    output logic         pc_valid
);

    logic [W-1:0] count;

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + W'(in_bits[i] ^ sub_mask[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= '0;
            pc_valid <= 1'b0;
        end else if (clr) begin
            pc_valid <= 1'b0;
        end else begin
            pc_valid <= valid;
            if (valid) begin
                pc <= count;
            end
        end
    end

endmodule

// File: rtl/u_scaled_addsub_n.sv
// rtl/u_scaled_addsub_n.sv - N-lane scaled unary adder/subtractor; USSUB_OCNT_EN adds oOnesCnt
module u_scaled_addsub_n
    import ussub_pkg::*;
#(
    parameter int NUM_IN   = 4,
    parameter int ACC_INIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic              iClk,
    input  logic              iRstN,
    input  logic              iValid,
    input  logic              iClr,
    input  logic [NUM_IN-1:0] iIn,
    input  logic [NUM_IN-1:0] iSubMask,
    output logic              oValid,
    output logic              oOut
`ifdef USSUB_OCNT_EN
    ,
    output logic [CNT_W-1:0]  oOnesCnt
`endif
);

    localparam int PC_W_L  = pc_w(NUM_IN);
    localparam int ACC_W_L = acc_w(NUM_IN);
    localparam int SUM_W_L = sum_w(NUM_IN);

    if (NUM_IN < 2) begin : g_chk_num_in
        $error("NUM_IN must be >= 2");
    end
    if (ACC_INIT < 0 || ACC_INIT >= NUM_IN) begin : g_chk_acc_init
        $error("ACC_INIT must be in [0, NUM_IN)");
    end
    if (CNT_W < 1) begin : g_chk_cnt_w
        $error("CNT_W must be >= 1");
    end

    logic [PC_W_L-1:0]  pc_q;
    logic               v1;
    logic [ACC_W_L-1:0] acc;
    logic [SUM_W_L-1:0] sum;

    u_popcnt_reg #(
        .N (NUM_IN),
        .W (PC_W_L)
    ) u_stage1 (
        .clk      (iClk),
        .rst_n    (iRstN),
        .clr      (iClr),
        .valid    (iValid),
        .in_bits  (iIn),
        .sub_mask (iSubMask),
        .pc       (pc_q),
        .pc_valid (v1)
    );

    assign sum = SUM_W_L'(acc) + SUM_W_L'(pc_q);

    // Carry out of the residue becomes the output bit; the residue stays below NUM_IN.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            acc    <= ACC_W_L'(ACC_INIT);
            oOut   <= 1'b0;
            oValid <= 1'b0;
        end else if (iClr) begin
            acc    <= ACC_W_L'(ACC_INIT);
            oOut   <= 1'b0;
            oValid <= 1'b0;
        end else if (v1) begin
            oValid <= 1'b1;
            if (sum >= SUM_W_L'(NUM_IN)) begin
                oOut <= 1'b1;
                acc  <= ACC_W_L'(sum - SUM_W_L'(NUM_IN));
            end else begin
                oOut <= 1'b0;
                acc  <= ACC_W_L'(sum);
            end
        end else begin
            oOut   <= 1'b0;
            oValid <= 1'b0;
        end
    end

`ifdef USSUB_OCNT_EN
    logic [CNT_W-1:0] ones_cnt;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            ones_cnt <= '0;
        end else if (iClr) begin
            ones_cnt <= '0;
        end else if (oValid && oOut && (ones_cnt != {CNT_W{1'b1}})) begin
            ones_cnt <= ones_cnt + 1'b1;
        end
    end

    assign oOnesCnt = ones_cnt;
`endif

endmodule

// File: tb/tb_u_scaled_addsub_n.sv
// tb/tb_u_scaled_addsub_n.sv - self-checking bench for three u_scaled_addsub_n configurations
module tb_u_scaled_addsub_n;

    logic iClk = 1'b0;
    logic iRstN, iValid, iClr;
    logic [3:0] in_a, m_a, in_c, m_c;
    logic [1:0] in_b, m_b;
    logic ov_a, oo_a, ov_b, oo_b, ov_c, oo_c;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b, cnt_c;

    always #5 iClk = ~iClk;

    u_scaled_addsub_n #(.NUM_IN(4), .ACC_INIT(0), .CNT_W(4)) dut_a (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .iClr(iClr),
        .iIn(in_a), .iSubMask(m_a), .oValid(ov_a), .oOut(oo_a)
`ifdef USSUB_OCNT_EN
        , .oOnesCnt(cnt_a)
`endif
    );

    u_scaled_addsub_n #(.NUM_IN(2), .ACC_INIT(0), .CNT_W(16)) dut_b (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .iClr(iClr),
        .iIn(in_b), .iSubMask(m_b), .oValid(ov_b), .oOut(oo_b)
`ifdef USSUB_OCNT_EN
        , .oOnesCnt(cnt_b)
`endif
    );

    u_scaled_addsub_n #(.NUM_IN(4), .ACC_INIT(2), .CNT_W(16)) dut_c (
        .iClk(iClk), .iRstN(iRstN), .iValid(iValid), .iClr(iClr),
        .iIn(in_c), .iSubMask(m_c), .oValid(ov_c), .oOut(oo_c)
`ifdef USSUB_OCNT_EN
        , .oOnesCnt(cnt_c)
`endif
    );

`ifndef USSUB_OCNT_EN
    assign cnt_a = '0;
    assign cnt_b = '0;
    assign cnt_c = '0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference: total = ACC_INIT + sum of lane popcounts; each output bit is the step in floor(total/N).
    int nn[3]   = '{4, 2, 4};
    int ini[3]  = '{0, 0, 2};
    int cmax[3] = '{15, 65535, 65535};
    int tot[3], pc1[3], e_oo[3], e_cnt[3];
    bit s1v, e_ov;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            tot[i] = ini[i];
            pc1[i] = 0;
            e_oo[i] = 0;
            e_cnt[i] = 0;
        end
        s1v = 1'b0;
        e_ov = 1'b0;
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":ov_a"}, 32'(ov_a), 32'(e_ov));
        chk({ph, ":oo_a"}, 32'(oo_a), 32'(e_oo[0]));
        chk({ph, ":ov_b"}, 32'(ov_b), 32'(e_ov));
        chk({ph, ":oo_b"}, 32'(oo_b), 32'(e_oo[1]));
        chk({ph, ":ov_c"}, 32'(ov_c), 32'(e_ov));
        chk({ph, ":oo_c"}, 32'(oo_c), 32'(e_oo[2]));
`ifdef USSUB_OCNT_EN
        chk({ph, ":cnt_a"}, 32'(cnt_a), 32'(e_cnt[0]));
        chk({ph, ":cnt_b"}, 32'(cnt_b), 32'(e_cnt[1]));
        chk({ph, ":cnt_c"}, 32'(cnt_c), 32'(e_cnt[2]));
`endif
    endtask

    task automatic step(input string ph, input bit v, input bit c,
                        input logic [3:0] a, input logic [3:0] ma,
                        input logic [1:0] b, input logic [1:0] mb,
                        input logic [3:0] cc, input logic [3:0] mc);
        int q;
        iValid = v; iClr = c;
        in_a = a; m_a = ma; in_b = b; m_b = mb; in_c = cc; m_c = mc;
        if (c) begin
            model_reset();
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (e_ov && e_oo[i] != 0 && e_cnt[i] < cmax[i]) e_cnt[i]++;
            end
            for (int i = 0; i < 3; i++) begin
                if (s1v) begin
                    q = tot[i] / nn[i];
                    tot[i] += pc1[i];
                    e_oo[i] = tot[i] / nn[i] - q;
                end else begin
                    e_oo[i] = 0;
                end
            end
            e_ov = s1v;
            s1v = v;
            if (v) begin
                pc1[0] = $countones(a ^ ma);
                pc1[1] = $countones(b ^ mb);
                pc1[2] = $countones(cc ^ mc);
            end
        end
        @(posedge iClk);
        #1;
        check_all(ph);
    endtask

    initial begin
        iRstN = 1'b0; iValid = 1'b0; iClr = 1'b0;
        in_a = '0; m_a = '0; in_b = '0; m_b = '0; in_c = '0; m_c = '0;
        model_reset();
        #12;
        chk("reset:ov_a", 32'(ov_a), 32'd0);
        chk("reset:oo_a", 32'(oo_a), 32'd0);
        chk("reset:ov_c", 32'(ov_c), 32'd0);
        chk("reset:cnt_a", 32'(cnt_a), 32'd0);
        iRstN = 1'b1;

        // All-ones lanes; legacy subtractor A=1,B=0; ACC_INIT=2 with one lane set
        for (int i = 0; i < 8; i++) step("full", 1, 0, 4'hF, 4'h0, 2'b01, 2'b10, 4'b0001, 4'h0);
        for (int i = 0; i < 3; i++) step("drain1", 0, 0, 4'h0, 4'h0, 2'b00, 2'b10, 4'h0, 4'h0);
        for (int i = 0; i < 6; i++) step("half", 1, 0, 4'b0011, 4'h0, 2'b10, 2'b10, 4'b0001, 4'h0);
        for (int i = 0; i < 3; i++) step("drain2", 0, 0, 4'h0, 4'h0, 2'b00, 2'b10, 4'h0, 4'h0);

        step("gap", 1, 0, 4'b0011, 4'h0, 2'b11, 2'b10, 4'b0011, 4'h0);
        step("gap", 0, 0, 4'b0011, 4'h0, 2'b11, 2'b10, 4'b0011, 4'h0);
        step("gap", 1, 0, 4'b0011, 4'h0, 2'b11, 2'b10, 4'b0011, 4'h0);
        step("gap", 1, 0, 4'b0011, 4'h0, 2'b11, 2'b10, 4'b0011, 4'h0);
        for (int i = 0; i < 2; i++) step("drain3", 0, 0, 4'h0, 4'h0, 2'b00, 2'b10, 4'h0, 4'h0);

        for (int i = 0; i < 3; i++) step("preclr", 1, 0, 4'b0011, 4'h0, 2'b11, 2'b10, 4'b0111, 4'h0);
        step("clr", 1, 1, 4'hF, 4'h0, 2'b01, 2'b10, 4'hF, 4'h0);
        step("postclr", 1, 0, 4'hF, 4'h0, 2'b01, 2'b10, 4'hF, 4'h0);
        chk("postclr:ov_a_low", 32'(ov_a), 32'd0);
        for (int i = 0; i < 20; i++) step("sat", 1, 0, 4'hF, 4'h0, 2'b01, 2'b10, 4'hF, 4'h0);
`ifdef USSUB_OCNT_EN
        chk("sat:cnt_a_max", 32'(cnt_a), 32'd15);
`endif

        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                iRstN = 1'b0;
                #2;
                chk("arst:ov_a", 32'(ov_a), 32'd0);
                chk("arst:oo_b", 32'(oo_b), 32'd0);
                chk("arst:ov_c", 32'(ov_c), 32'd0);
                model_reset();
                iRstN = 1'b1;
            end
            step("rand", ($urandom % 4) != 0, ($urandom % 40) == 0,
                 4'($urandom), 4'($urandom), 2'($urandom), 2'($urandom),
                 4'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
